// File: rtl/joy_shift_reader.sv
// Scans two 8-button joysticks through an external 74HC165 chain and publishes
// their active-high state once two consecutive frames agree.
module joy_shift_reader #(
  parameter int DIV = 12,
  parameter int GAP = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic joy_data,
  output logic joy_load_n,
  output logic joy_clk,
  output logic joy1_up,
  output logic joy1_down,
  output logic joy1_left,
  output logic joy1_right,
  output logic joy1_fire1,
  output logic joy1_fire2,
  output logic joy1_fire3,
  output logic joy1_start,
  output logic joy2_up,
  output logic joy2_down,
  output logic joy2_left,
  output logic joy2_right,
  output logic joy2_fire1,
  output logic joy2_fire2,
  output logic joy2_fire3,
  output logic joy2_start,
  output logic frame_strobe
);
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_UPDATE, ST_GAP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  logic          load_n_q, load_n_d;
  logic          jclk_q, jclk_d;
  logic          strobe_q, strobe_d;
  logic [1:0]    sync_q, sync_d;
  logic [15:0]   raw_q, raw_d;
  logic [15:0]   prev_q, prev_d;
  logic [15:0]   joy_q, joy_d;
  logic          tick;

  assign tick = (tick_cnt_q == TW'(DIV - 1));

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    load_n_d   = load_n_q;
    jclk_d     = jclk_q;
    strobe_d   = 1'b0;
    sync_d     = {sync_q[0], joy_data};
    raw_d      = raw_q;
    prev_d     = prev_q;
    joy_d      = joy_q;
    // The counter pauses for the single UPDATE clock, so a frame runs one
    // clock past a whole number of ticks.
    if (state_q != ST_UPDATE) tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    case (state_q)
      ST_LOAD: if (tick) begin
        // First tick drops the strobe; the next one releases it and starts shifting.
        if (load_n_q) begin
          load_n_d = 1'b0;
        end else begin
          load_n_d = 1'b1;
          state_d  = ST_SHIFT;
          idx_d    = 4'd0;
          phase_d  = 1'b0;
        end
      end
      ST_SHIFT: if (tick) begin
        if (!phase_q) begin
          raw_d[4'd15 - idx_q] = sync_q[1];
          jclk_d  = 1'b1;
          phase_d = 1'b1;
        end else begin
          jclk_d  = 1'b0;
          phase_d = 1'b0;
          if (idx_q == 4'd15) state_d = ST_UPDATE;
          else                idx_d   = idx_q + 4'd1;
        end
      end
      ST_UPDATE: begin
        if (raw_q == prev_q) joy_d = ~raw_q;
        prev_d    = raw_q;
        strobe_d  = 1'b1;
        gap_cnt_d = '0;
        state_d   = ST_GAP;
      end
      ST_GAP: if (tick) begin
        if (gap_cnt_q == GW'(GAP - 1)) begin
          gap_cnt_d = '0;
          load_n_d  = 1'b0;
          state_d   = ST_LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_LOAD;
      tick_cnt_q <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= 4'd0;
      phase_q    <= 1'b0;
      load_n_q   <= 1'b1;
      jclk_q     <= 1'b0;
      strobe_q   <= 1'b0;
      sync_q     <= 2'b11;
      raw_q      <= 16'hFFFF;
      prev_q     <= 16'hFFFF;
      joy_q      <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      load_n_q   <= load_n_d;
      jclk_q     <= jclk_d;
      strobe_q   <= strobe_d;
      sync_q     <= sync_d;
      raw_q      <= raw_d;
      prev_q     <= prev_d;
      joy_q      <= joy_d;
    end
  end

  assign joy_load_n   = load_n_q;
  assign joy_clk      = jclk_q;
  assign frame_strobe = strobe_q;
  assign {joy1_up, joy1_down, joy1_left, joy1_right,
          joy1_fire1, joy1_fire2, joy1_fire3, joy1_start} = joy_q[15:8];
  assign {joy2_up, joy2_down, joy2_left, joy2_right,
          joy2_fire1, joy2_fire2, joy2_fire3, joy2_start} = joy_q[7:0];
endmodule
